// File: rtl/reg_wport_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_wport_arbiter_pkg
// Purpose  : Shared constants for the register-file port arbiters.
//            Covers the register geometry, the default requester count and
//            the fixed requester slots.
// Revision : 1.0 - initial release
// ============================================================================
package reg_wport_arbiter_pkg;

  // Register file geometry
  localparam int REG_AW        = 5;
  localparam int REG_DW        = 32;
  localparam int REG_ZERO_ADDR = 0;

  // Default number of write-port requesters and their fixed slots
  localparam int ARB_NREQ = 3;
  localparam int REQ_WB   = 0;  // CPU writeback
  localparam int REQ_MD   = 1;  // multi-cycle mul/div
  localparam int REQ_DBG  = 2;  // debug port

endpackage : reg_wport_arbiter_pkg
`default_nettype wire

// File: rtl/reg_wport_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker. Starting at ptr and moving
//            upward modulo N, it returns the first set bit of valid as a
//            one-hot grant together with its index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
  import reg_wport_arbiter_pkg::*;
#(
  parameter int N  = ARB_NREQ,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  // pos is one bit wider than ptr so that ptr+k can be folded back below N
  logic [PW:0] pos;

  // Scan the N positions from ptr onward and take the first valid one
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= (PW+1)'(N)) begin
        pos = pos - (PW+1)'(N);
      end
      if (!any && valid[pos[PW-1:0]]) begin
        any                = 1'b1;
        grant[pos[PW-1:0]] = 1'b1;
        idx                = pos[PW-1:0];
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/reg_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_wport_arbiter
// Purpose  : Shares the single register-file write port among NREQ
//            requesters. Each requester has a valid/ready handshake, and the
//            arbiter uses round-robin selection. A single registered stage
//            drives the write address, write data and write enable.
// Revision : 1.0 - initial release
// ============================================================================
module reg_wport_arbiter
  import reg_wport_arbiter_pkg::*;
#(
  parameter int NREQ = ARB_NREQ,
  parameter int AW   = REG_AW,
  parameter int DW   = REG_DW
) (
  input  logic             clk,
  input  logic             rst,        // synchronous, active low
  input  logic             hold,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  req_ready,
  output logic [AW-1:0]    reg_W_addr,
  output logic [DW-1:0]    wdata,
  output logic             reg_we,
  output logic             busy
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;
  logic [NREQ-1:0] valid_gated;
  logic [NREQ-1:0] grant;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            we_q;

  // Reset and debug freeze both block new grants. Requesters keep their
  // valid asserted, so they are simply arbitrated again later.
  assign valid_gated = (rst && !hold) ? req_valid : '0;

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_rr_pick (
    .valid (valid_gated),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign req_ready = grant;

  // The grant is one-hot, so OR-ing the masked fields acts as a mux
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = sel_addr | req_addr[i*AW +: AW];
        sel_data = sel_data | req_data[i*DW +: DW];
      end
    end
  end

  // Round-robin pointer and output stage. A write to r0 completes the
  // handshake but never raises the write enable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr     <= '0;
      we_q       <= 1'b0;
      reg_W_addr <= '0;
      wdata      <= '0;
    end else if (pick_any) begin
      rr_ptr     <= (pick_idx == PW'(NREQ-1)) ? '0 : pick_idx + 1'b1;
      we_q       <= (sel_addr != AW'(REG_ZERO_ADDR));
      reg_W_addr <= sel_addr;
      wdata      <= sel_data;
    end else begin
      we_q       <= 1'b0;
    end
  end

  // A write still held in the stage when reset arrives is dropped here and
  // never reaches the register file.
  assign reg_we = we_q & rst;
  assign busy   = (|req_valid) | reg_we;

endmodule : reg_wport_arbiter
`default_nettype wire

// File: tb/tb_reg_wport_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_wport_arbiter
// Purpose  : Scoreboard bench for reg_wport_arbiter. It runs directed
//            scenarios followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_wport_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic               clk;
  logic               rst;
  logic               hold;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [AW-1:0]      reg_W_addr;
  logic [DW-1:0]      wdata;
  logic               reg_we;
  logic               busy;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  bit   run         = 1'b0;
  int   m_ptr       = 0;
  exp_t exp_q[$];

  bit            cur_v [NREQ];
  logic [AW-1:0] cur_a [NREQ];
  logic [DW-1:0] cur_d [NREQ];

  logic [DW-1:0] rf_model [32];
  logic [DW-1:0] rf_dut   [32];

  reg_wport_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .reg_W_addr (reg_W_addr),
    .wdata      (wdata),
    .reg_we     (reg_we),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The register file, fed only by the DUT outputs
  always @(posedge clk) begin
    if (reg_we) rf_dut[reg_W_addr] <= wdata;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic post(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (!cur_v[i]) begin
      cur_v[i] = 1'b1;
      cur_a[i] = a;
      cur_d[i] = d;
    end
  endtask

  // Runs one clock cycle from posedge+1 to the next posedge+1. It drives the
  // inputs, predicts the grant from the round-robin rule, checks req_ready
  // and queues the expected register write for the next cycle.
  task automatic drive(input bit r, input bit h);
    int g;
    int p;
    logic [NREQ-1:0] exp_rdy;
    rst  = r;
    hold = h;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = cur_v[i];
      req_addr[i*AW +: AW] = cur_a[i];
      req_data[i*DW +: DW] = cur_d[i];
    end
    // A write due this cycle is lost on reset; otherwise it commits
    if (!r) begin
      while (exp_q.size() > 0 && exp_q[0].due == cyc) void'(exp_q.pop_front());
    end else begin
      foreach (exp_q[j]) if (exp_q[j].due == cyc) rf_model[exp_q[j].addr] = exp_q[j].data;
    end
    g = -1;
    if (r && !h) begin
      for (int k = 0; k < NREQ; k++) begin
        p = (m_ptr + k) % NREQ;
        if (g < 0 && cur_v[p]) g = p;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    #1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (!r) begin
      m_ptr = 0;
    end else if (g >= 0) begin
      m_ptr = (g + 1) % NREQ;
      if (cur_a[g] != '0) exp_q.push_back('{cyc + 1, cur_a[g], cur_d[g]});
    end
    @(posedge clk);
    #1;
    cyc++;
    if (g >= 0) cur_v[g] = 1'b0;
  endtask

  // Monitor: the write port must show exactly the writes the scoreboard expects
  always @(negedge clk) begin
    if (run) begin
      automatic bit exp_we = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("reg_we", 64'(reg_we), 64'(exp_we));
      if (exp_we) begin
        chk("reg_W_addr", 64'(reg_W_addr), 64'(exp_q[0].addr));
        chk("wdata", 64'(wdata), 64'(exp_q[0].data));
        void'(exp_q.pop_front());
      end
      chk("busy", 64'(busy), 64'((|req_valid) | exp_we));
    end
  end

  initial begin
    bit r;
    bit h;
    logic [DW-1:0] da;
    logic [DW-1:0] db;
    for (int i = 0; i < 32; i++) begin
      rf_model[i] = '0;
      rf_dut[i]   = '0;
    end
    for (int i = 0; i < NREQ; i++) begin
      cur_v[i] = 1'b0;
      cur_a[i] = '0;
      cur_d[i] = '0;
    end
    rst = 1'b0; hold = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    @(posedge clk);
    #1;
    run = 1'b1;

    // Reset with pending work, then release: requester 0 must win first
    for (int i = 0; i < NREQ; i++) post(i, AW'(i + 1), $urandom());
    drive(0, 0);
    drive(0, 0);
    repeat (4) drive(1, 0);

    // Single write from requester 1
    post(1, 5'd5, 32'hDEADBEEF);
    drive(1, 0);
    repeat (2) drive(1, 0);

    // Round-robin fairness from a reset pointer
    drive(0, 0);
    repeat (6) begin
      for (int i = 0; i < NREQ; i++) post(i, AW'(i + 1), $urandom());
      drive(1, 0);
    end
    repeat (3) drive(1, 0);

    // r0 protection
    post(0, 5'd0, 32'hFFFFFFFF);
    drive(1, 0);
    repeat (2) drive(1, 0);
    chk("r0", 64'(rf_dut[0]), 64'd0);

    // Hold: the pending write completes, and no new grants are issued
    post(0, 5'd9, $urandom());
    drive(1, 0);
    post(2, 5'd10, $urandom());
    repeat (3) drive(1, 1);
    drive(1, 0);
    repeat (2) drive(1, 0);

    // Same-address conflict: requester 0 first, then 1, so B is final
    da = 32'hAAAA_0001;
    db = 32'hBBBB_0002;
    drive(0, 0);
    post(0, 5'd7, da);
    post(1, 5'd7, db);
    repeat (4) drive(1, 0);
    chk("r7", 64'(rf_dut[7]), 64'(db));

    // Randomized traffic with occasional reset and hold
    repeat (300) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!cur_v[i] && $urandom_range(1, 0) == 1)
          post(i, AW'($urandom_range(31, 0)), $urandom());
      end
      r = ($urandom_range(99, 0) >= 3);
      h = ($urandom_range(99, 0) < 15);
      drive(r, h);
    end
    repeat (NREQ + 3) drive(1, 0);

    for (int i = 0; i < 32; i++) chk($sformatf("rf[%0d]", i), 64'(rf_dut[i]), 64'(rf_model[i]));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_reg_wport_arbiter
`default_nettype wire
